// File: rtl/phase_sequencer_if.sv
// Sequencer-to-datapath bundle: run/step/decode inputs, phase code, strobes and status.
// The sequencer takes the master side; the datapath/board logic takes the slave side.
interface phase_sequencer_if;
    logic        run;
    logic        step;
    logic        instr_zero;
    logic [3:0]  estado;
    logic        if_en;
    logic        id_en;
    logic        ex_en;
    logic        mem_en;
    logic        wb_en;
    logic        pc_en;
    logic        busy;
    logic        halted;
    logic [31:0] instr_retired;
    logic [31:0] cycle_count;

    modport master (
        input  run, step, instr_zero,
        output estado, if_en, id_en, ex_en, mem_en, wb_en, pc_en,
        output busy, halted, instr_retired, cycle_count
    );

    modport slave (
        output run, step, instr_zero,
        input  estado, if_en, id_en, ex_en, mem_en, wb_en, pc_en,
        input  busy, halted, instr_retired, cycle_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multicycle RISC-V phase sequencer with parameterised EX/WB hold counts.
// Optional perf counters are built only when PHASE_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for run or a step pulse
// IF     | instruction fetch, 1 cycle
// ID     | decode; all-zero instruction goes to HALT
// EX     | execute, 1+EX_WAIT cycles
// MEM    | memory access, 1 cycle
// WB     | write-back, 1+WB_WAIT cycles
// PC     | PC update and run/step decision
// HALT   | stopped until reset
module phase_sequencer #(
    parameter int unsigned EX_WAIT = 2,
    parameter int unsigned WB_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    phase_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IF   = 4'b0000,
        S_ID   = 4'b0001,
        S_EX   = 4'b0010,
        S_MEM  = 4'b0011,
        S_WB   = 4'b0100,
        S_PC   = 4'b1000,
        S_HALT = 4'b1001,
        S_IDLE = 4'b1010
    } state_t;

    localparam logic [3:0] LP_EX_WAIT = 4'(EX_WAIT);
    localparam logic [3:0] LP_WB_WAIT = 4'(WB_WAIT);

    state_t     r_state;
    logic [3:0] r_wait;
    logic       r_single;
    logic       r_if_en, r_id_en, r_ex_en, r_mem_en, r_wb_en, r_pc_en;
    logic       r_busy, r_halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_wait   <= 4'd0;
            r_single <= 1'b0;
            r_if_en  <= 1'b0;
            r_id_en  <= 1'b0;
            r_ex_en  <= 1'b0;
            r_mem_en <= 1'b0;
            r_wb_en  <= 1'b0;
            r_pc_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_if_en  <= 1'b0;
            r_id_en  <= 1'b0;
            r_ex_en  <= 1'b0;
            r_mem_en <= 1'b0;
            r_wb_en  <= 1'b0;
            r_pc_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state <= S_IF;
                        r_if_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (bus.step) begin
                        r_state  <= S_IF;
                        r_if_en  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_single <= 1'b1;
                    end
                end
                S_IF: begin
                    r_state <= S_ID;
                    r_id_en <= 1'b1;
                end
                S_ID: begin
                    if (bus.instr_zero) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EX;
                        r_ex_en <= 1'b1;
                        r_wait  <= LP_EX_WAIT;
                    end
                end
                S_EX: begin
                    if (r_wait == 4'd0) begin
                        r_state  <= S_MEM;
                        r_mem_en <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_MEM: begin
                    r_state <= S_WB;
                    r_wb_en <= 1'b1;
                    r_wait  <= LP_WB_WAIT;
                end
                S_WB: begin
                    if (r_wait == 4'd0) begin
                        r_state <= S_PC;
                        r_pc_en <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_PC: begin
                    // Single-step mode always returns to IDLE once, even if run rose meanwhile.
                    if (bus.run && !r_single) begin
                        r_state <= S_IF;
                        r_if_en <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_single <= 1'b0;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.estado = r_state;
    assign bus.if_en  = r_if_en;
    assign bus.id_en  = r_id_en;
    assign bus.ex_en  = r_ex_en;
    assign bus.mem_en = r_mem_en;
    assign bus.wb_en  = r_wb_en;
    assign bus.pc_en  = r_pc_en;
    assign bus.busy   = r_busy;
    assign bus.halted = r_halted;

`ifdef PHASE_PERF_CNT_EN
    logic [31:0] r_instr_retired;
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_retired <= 32'd0;
            r_cycle_count   <= 32'd0;
        end else begin
            if (r_pc_en) r_instr_retired <= r_instr_retired + 32'd1;
            if (r_busy)  r_cycle_count   <= r_cycle_count + 32'd1;
        end
    end

    assign bus.instr_retired = r_instr_retired;
    assign bus.cycle_count   = r_cycle_count;
`else
    assign bus.instr_retired = 32'd0;
    assign bus.cycle_count   = 32'd0;
`endif
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer at default waits (EX_WAIT=2, WB_WAIT=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_phase_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    phase_sequencer_if bus_if ();

    phase_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {estado, if,id,ex,mem,wb,pc, busy, halted} for the 10 cycles of one instruction.
    localparam logic [11:0] EXP_INSTR [10] = '{
        {4'b0000, 6'b100000, 1'b1, 1'b0},
        {4'b0001, 6'b010000, 1'b1, 1'b0},
        {4'b0010, 6'b001000, 1'b1, 1'b0},
        {4'b0010, 6'b000000, 1'b1, 1'b0},
        {4'b0010, 6'b000000, 1'b1, 1'b0},
        {4'b0011, 6'b000100, 1'b1, 1'b0},
        {4'b0100, 6'b000010, 1'b1, 1'b0},
        {4'b0100, 6'b000000, 1'b1, 1'b0},
        {4'b0100, 6'b000000, 1'b1, 1'b0},
        {4'b1000, 6'b000001, 1'b1, 1'b0}
    };
    localparam logic [11:0] EXP_IDLE = {4'b1010, 6'b000000, 1'b0, 1'b0};
    localparam logic [11:0] EXP_HALT = {4'b1001, 6'b000000, 1'b0, 1'b1};

    function automatic logic [11:0] obs();
        return {bus_if.estado, bus_if.if_en, bus_if.id_en, bus_if.ex_en,
                bus_if.mem_en, bus_if.wb_en, bus_if.pc_en, bus_if.busy, bus_if.halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus_if.run = 1'b0;
        bus_if.step = 1'b0;
        bus_if.instr_zero = 1'b0;

        // Reset held 3 cycles, then idle for 20 cycles.
        repeat (3) cyc();
        chk("reset_state", 32'(obs()), 32'(EXP_IDLE));
        chk("reset_retired", bus_if.instr_retired, 32'd0);
        chk("reset_cycles", bus_if.cycle_count, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_hold", 32'(obs()), 32'(EXP_IDLE));
        end

        // Free-run: five instructions, 10-cycle period.
        bus_if.run = 1'b1;
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 10; k++) begin
                cyc();
                chk($sformatf("run_i%0d_c%0d", n, k), 32'(obs()), 32'(EXP_INSTR[k]));
            end
        end

        // Sixth instruction: IF, ID, then run drops on the first EX cycle.
        cyc();
        chk("run6_if", 32'(obs()), 32'(EXP_INSTR[0]));
`ifdef PHASE_PERF_CNT_EN
        chk("perf_retired5", bus_if.instr_retired, 32'd5);
        chk("perf_cycles50", bus_if.cycle_count, 32'd50);
`else
        chk("perf_retired_off", bus_if.instr_retired, 32'd0);
        chk("perf_cycles_off", bus_if.cycle_count, 32'd0);
`endif
        cyc();
        chk("run6_id", 32'(obs()), 32'(EXP_INSTR[1]));
        cyc();
        chk("run6_ex", 32'(obs()), 32'(EXP_INSTR[2]));
        bus_if.run = 1'b0;
        for (int k = 3; k < 10; k++) begin
            cyc();
            chk($sformatf("rundrop_c%0d", k), 32'(obs()), 32'(EXP_INSTR[k]));
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rundrop_idle", 32'(obs()), 32'(EXP_IDLE));
        end

        // Single step with a second pulse 4 cycles later that must be ignored.
        bus_if.step = 1'b1;
        cyc();
        bus_if.step = 1'b0;
        chk("step_c0", 32'(obs()), 32'(EXP_INSTR[0]));
        for (int k = 1; k < 10; k++) begin
            bus_if.step = (k == 4);
            cyc();
            chk($sformatf("step_c%0d", k), 32'(obs()), 32'(EXP_INSTR[k]));
        end
        bus_if.step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("step_back_idle", 32'(obs()), 32'(EXP_IDLE));
        end

        // Run rises during a single step: one return to IDLE, then restart.
        bus_if.step = 1'b1;
        cyc();
        bus_if.step = 1'b0;
        chk("ss_run_c0", 32'(obs()), 32'(EXP_INSTR[0]));
        for (int k = 1; k < 10; k++) begin
            bus_if.run = (k >= 3);
            cyc();
            chk($sformatf("ss_run_c%0d", k), 32'(obs()), 32'(EXP_INSTR[k]));
        end
        cyc();
        chk("ss_run_idle_once", 32'(obs()), 32'(EXP_IDLE));

        // Restarted instruction completes, then the next one decodes all-zero.
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("pre_halt_c%0d", k), 32'(obs()), 32'(EXP_INSTR[k]));
        end
        cyc();
        chk("halt_instr_if", 32'(obs()), 32'(EXP_INSTR[0]));
        bus_if.instr_zero = 1'b1;
        cyc();
        chk("halt_instr_id", 32'(obs()), 32'(EXP_INSTR[1]));
        cyc();
        chk("halt_enter", 32'(obs()), 32'(EXP_HALT));
        bus_if.instr_zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_if.run = i[0];
            bus_if.step = i[1];
            cyc();
            chk("halt_sticky", 32'(obs()), 32'(EXP_HALT));
        end
        bus_if.run = 1'b0;
        bus_if.step = 1'b0;
        rst = 1'b0;
        #1;
        chk("halt_reset_async", 32'(obs()), 32'(EXP_IDLE));
        cyc();
        rst = 1'b1;
        cyc();
        chk("halt_reset_idle", 32'(obs()), 32'(EXP_IDLE));

        // Reset during the WB wait aborts the instruction.
        bus_if.run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("wbrst_c%0d", k), 32'(obs()), 32'(EXP_INSTR[k]));
        end
        rst = 1'b0;
        bus_if.run = 1'b0;
        #1;
        chk("wbrst_async", 32'(obs()), 32'(EXP_IDLE));
        chk("wbrst_retired", bus_if.instr_retired, 32'd0);
        chk("wbrst_cycles", bus_if.cycle_count, 32'd0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("wbrst_no_strobe", 32'(obs()), 32'(EXP_IDLE));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Central sequencer for the multicycle RISC-V datapath. It replaces the fixed AUX delay states with parameterised wait counts.
- Drives the datapath phase code and one-cycle phase strobes (IF, ID, EX, MEM, WB, PC update).
- Supports free-run and single-step execution from FPGA switches/buttons, and halts on an all-zero instruction.

Parameters:
- EX_WAIT, 2, extra hold cycles after the EX strobe (0..15)
- WB_WAIT, 2, extra hold cycles after the WB strobe (0..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = execute instructions back-to-back
- step  in  1  single-cycle pulse (already debounced and edge-detected); starts one instruction when idle
- instr_zero  in  1  from decode; 1 when the fetched instruction is 32'h0, sampled in ID
- estado  out  4  current phase code to the datapath
- if_en, id_en, ex_en, mem_en, wb_en, pc_en  out  1 each  registered phase strobes, high only on the first cycle of their phase
- busy  out  1  high from IF through PC of an instruction
- halted  out  1  high in HALT
- instr_retired  out  32  retired-instruction count (optional feature)
- cycle_count  out  32  active-cycle count (optional feature)

Behaviour:
- Phase codes:
  - IDLE=4'b1010, IF=4'b0000, ID=4'b0001, EX=4'b0010, MEM=4'b0011, WB=4'b0100, PC=4'b1000, HALT=4'b1001.
  - estado keeps the phase code during wait cycles.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; estado=4'b1010.
  - All strobes, busy, halted and counters are 0; wait counter is 0.
  - Reset mid-instruction aborts the instruction: no further strobes.
- IDLE:
  - run=1 → IF on the next edge.
  - Else step=1 → IF and latch single-step mode.
  - Otherwise stay.
  - run and step high together: run wins; no single-step latch.
- IF (1 cycle, if_en=1) → ID.
- ID (1 cycle, id_en=1):
  - instr_zero=1 → HALT.
  - Otherwise → EX.
- EX:
  - First cycle ex_en=1; the wait counter loads EX_WAIT.
  - State holds until the counter reaches 0, then → MEM.
  - Phase lasts 1+EX_WAIT cycles.
- MEM (1 cycle, mem_en=1) → WB.
- WB: first cycle wb_en=1, then holds WB_WAIT cycles, then → PC.
- PC (1 cycle, pc_en=1):
  - → IF if run=1 and not in single-step mode.
  - Otherwise → IDLE, clearing the single-step latch.
- HALT:
  - halted=1 and busy=0; no strobes.
  - Leaves HALT only through reset. run and step are ignored.
- busy is 1 in IF, ID, EX, MEM, WB and PC, including wait cycles.
- Strobes are mutually exclusive: at most one of if_en..pc_en is high in any cycle.
- Instruction latency: 6+EX_WAIT+WB_WAIT cycles from the if_en edge to the next if_en edge in run mode (10 cycles at defaults).
- run falling mid-instruction: the current instruction completes through PC, then → IDLE.
- step while busy or halted: ignored, not queued.
- run rising during single-step: takes effect at the PC decision. Because single-step mode is latched, the sequencer still returns to IDLE once, then restarts from IDLE.
- EX_WAIT=0 or WB_WAIT=0: the phase lasts exactly 1 cycle.

Optional Feature:
- Macro PHASE_PERF_CNT_EN.
- When defined:
  - instr_retired increments by 1 in each pc_en cycle.
  - cycle_count increments every cycle that busy=1.
  - Both wrap from 32'hFFFFFFFF to 0 and are cleared only by reset.
- When undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- rst low 3 cycles, then high with run=0, step=0 → estado=4'b1010, all strobes 0, busy=0, for 20 cycles.
- run=1, instr_zero=0, defaults → strobe order IF,ID,EX,MEM,WB,PC. EX lasts 3 cycles, WB lasts 3. if_en rises every 10 cycles; with PHASE_PERF_CNT_EN, after 5 instructions instr_retired=5 and cycle_count=50.
- run=0; one step pulse, then a second pulse 4 cycles later → exactly one instruction (one pc_en); the second pulse is ignored. Back in IDLE 10 cycles after the first pulse.
- run=1, instr_zero=1 in the 2nd instruction's ID → HALT (estado=4'b1001, halted=1) on the next edge. No ex_en follows; toggling run/step has no effect; rst low returns to IDLE.
- run=1 dropped during EX → MEM, WB and PC strobes still occur once, then IDLE. No further if_en.
- rst low for 1 cycle during WB wait → immediate IDLE, wb/pc strobes absent. Counters cleared with the feature enabled; EX_WAIT=0, WB_WAIT=0 build gives 6-cycle instruction period.
